// File: rtl/wb_uart_rx.sv
// Wishbone-slave 8N1 UART receiver with a small byte FIFO and a level interrupt.
// Bit period is DIVIDER+2 clocks, latched per frame so mid-frame DIVIDER writes are harmless.
module wb_uart_rx #(
   parameter int WB_DATA_WIDTH = 32,
   parameter int WB_ADDR_WIDTH = 32,
   parameter int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     uart_rx_i,
   input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
   input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
   input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
   input  logic                     wb_we_i,
   input  logic                     wb_cyc_i,
   input  logic                     wb_stb_i,
   output logic                     wb_ack_o,
   output logic [WB_DATA_WIDTH-1:0] wb_data_o,
   output logic                     irq_o
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [31:0] SANITY = 32'h0B0BE71A;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } rx_state_e;

   logic [1:0]    sync_r;
   logic          rx_s;
   logic          rx_d_r;
   rx_state_e     state_r;
   logic [31:0]   div_l_r;
   logic [32:0]   cnt_r;
   logic [2:0]    bit_cnt_r;
   logic [7:0]    shift_r;
   logic          push_r;
   logic [7:0]    push_byte_r;
   logic          fe_set_r;
   logic [32:0]   period_s;
   logic [32:0]   half_s;

   logic          ack_r;
   logic [31:0]   data_r;
   logic [31:0]   divider_r;
   logic [31:0]   rdata_s;
   logic          access_s;
   logic          pop_s;
   logic          stat_clr_s;

   logic [7:0]    mem_r [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_nxt_s;
   logic          full_s;
   logic          not_empty_s;
   logic          push_ok_s;
   logic          overrun_r;
   logic          frame_err_r;
   logic          irq_r;
   logic [31:0]   status_s;
   logic          unused_bus_s;

   assign unused_bus_s = ^{wb_sel_i, wb_addr_i[WB_ADDR_WIDTH-1:4], wb_addr_i[1:0]};

   assign rx_s     = sync_r[1];
   assign period_s = {1'b0, div_l_r} + 33'd2;
   assign half_s   = period_s >> 1;

   // Two-flop synchroniser plus delayed copy for falling-edge detection
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_r <= 2'b11;
         rx_d_r <= 1'b1;
      end else begin
         sync_r <= {sync_r[0], uart_rx_i};
         rx_d_r <= rx_s;
      end
   end

   // Receive FSM: mid-bit sampling, stop-bit check and break hold-off
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r     <= ST_IDLE;
         div_l_r     <= 32'd1;
         cnt_r       <= 33'd0;
         bit_cnt_r   <= 3'd0;
         shift_r     <= 8'd0;
         push_r      <= 1'b0;
         push_byte_r <= 8'd0;
         fe_set_r    <= 1'b0;
      end else begin
         push_r   <= 1'b0;
         fe_set_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (rx_d_r && !rx_s) begin
                  div_l_r   <= divider_r;
                  cnt_r     <= 33'd0;
                  bit_cnt_r <= 3'd0;
                  state_r   <= ST_START;
               end
            end
            ST_START: begin
               if (cnt_r == half_s - 33'd1) begin
                  cnt_r   <= 33'd0;
                  state_r <= rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  cnt_r <= cnt_r + 33'd1;
               end
            end
            ST_DATA: begin
               if (cnt_r == period_s - 33'd1) begin
                  cnt_r   <= 33'd0;
                  shift_r <= {rx_s, shift_r[7:1]};
                  if (bit_cnt_r == 3'd7) begin
                     state_r <= ST_STOP;
                  end else begin
                     bit_cnt_r <= bit_cnt_r + 3'd1;
                  end
               end else begin
                  cnt_r <= cnt_r + 33'd1;
               end
            end
            ST_STOP: begin
               if (cnt_r == period_s - 33'd1) begin
                  cnt_r <= 33'd0;
                  if (rx_s) begin
                     push_r      <= 1'b1;
                     push_byte_r <= shift_r;
                     state_r     <= ST_IDLE;
                  end else begin
                     fe_set_r <= 1'b1;
                     state_r  <= ST_BREAK;
                  end
               end else begin
                  cnt_r <= cnt_r + 33'd1;
               end
            end
            ST_BREAK: begin
               if (rx_s) begin
                  state_r <= ST_IDLE;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   assign access_s   = wb_cyc_i & wb_stb_i & ~ack_r;
   assign pop_s      = access_s & ~wb_we_i & (wb_addr_i[3:2] == 2'd1) & not_empty_s;
   assign stat_clr_s = access_s & ~wb_we_i & (wb_addr_i[3:2] == 2'd2);
   assign full_s      = (count_r == CW'(FIFO_DEPTH));
   assign not_empty_s = (count_r != {CW{1'b0}});
   assign push_ok_s   = push_r & (~full_s | pop_s);
   assign status_s    = {24'h0, 4'(count_r), frame_err_r, overrun_r, full_s, not_empty_s};

   // Read-data mux, sampled into data_r on the access cycle
   always_comb begin
      rdata_s = 32'h0;
      case (wb_addr_i[3:2])
         2'd0:    rdata_s = divider_r;
         2'd1:    rdata_s = not_empty_s ? {24'h0, mem_r[rd_ptr_r]} : 32'h0;
         2'd2:    rdata_s = status_s;
         2'd3:    rdata_s = SANITY;
         default: rdata_s = 32'h0;
      endcase
   end

   // Next FIFO occupancy; simultaneous push and pop cancel out
   always_comb begin
      count_nxt_s = count_r;
      if (push_ok_s && !pop_s) begin
         count_nxt_s = count_r + CW'(1);
      end else if (!push_ok_s && pop_s) begin
         count_nxt_s = count_r - CW'(1);
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Bus handshake, registered read data and DIVIDER register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ack_r     <= 1'b0;
         data_r    <= 32'h0;
         divider_r <= 32'd1;
      end else begin
         ack_r  <= access_s;
         data_r <= (access_s && !wb_we_i) ? rdata_s : 32'h0;
         if (access_s && wb_we_i && (wb_addr_i[3:2] == 2'd0)) begin
            divider_r <= wb_data_i[31:0];
         end
      end
   end

   // FIFO storage, pointers, sticky flags and interrupt
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= 8'd0;
         end
         wr_ptr_r    <= {PW{1'b0}};
         rd_ptr_r    <= {PW{1'b0}};
         count_r     <= {CW{1'b0}};
         overrun_r   <= 1'b0;
         frame_err_r <= 1'b0;
         irq_r       <= 1'b0;
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_byte_r;
            wr_ptr_r        <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         count_r     <= count_nxt_s;
         overrun_r   <= (push_r & full_s & ~pop_s) | (overrun_r & ~stat_clr_s);
         frame_err_r <= fe_set_r | (frame_err_r & ~stat_clr_s);
         irq_r       <= (count_nxt_s != {CW{1'b0}});
      end
   end

   assign wb_ack_o  = ack_r & wb_cyc_i;
   assign wb_data_o = data_r;
   assign irq_o     = irq_r;
endmodule
